// File: rtl/sbox_trace_pkg.sv
// Shared definitions for the S-box power-analysis target: FSM state encoding,
// LFSR geometry/taps/seed and the lane width.
package sbox_trace_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ADVANCE = 3'd2,
        ROUND   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int LANE_W = 8;

    localparam int LFSR_W     = 32;
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'hACE1ACE1;

    // Fibonacci step: shift left, feedback of taps 32,22,2,1 enters at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// AES S-box (forward and inverse) as combinational logic: GF(2^8) inversion
// (x^254) combined with the forward or inverse affine transform.
module aes_sbox_lut (
    input  logic [7:0] a,
    input  logic       inv,
    output logic [7:0] y
);

    localparam logic [7:0] AFF_C   = 8'h63;
    localparam logic [7:0] AFF_D   = 8'h05;
    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] m;
        acc = 8'h00;
        m   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ m;
            m = xtime(m);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse for x != 0 and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ AFF_C[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = s[(i+2)%8] ^ s[(i+5)%8] ^ s[(i+7)%8] ^ AFF_D[i];
        end
        return b;
    endfunction

    // Select forward or inverse substitution.
    always_comb begin
        y = inv ? gf_inv(inv_affine(a)) : fwd_affine(gf_inv(a));
    end

endmodule

// File: rtl/trace_lfsr32.sv
// 32-bit Fibonacci LFSR plaintext source; advances only when shift_en is high.
module trace_lfsr32
    import sbox_trace_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    output logic [LFSR_W-1:0] q
);

    // LFSR register, reloaded with the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (shift_en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sbox_trace_target.sv
// Power-analysis target: NUM_LANES AES S-box lanes iterated NUM_ROUNDS times on
// LFSR plaintext XOR key, launched by start or by the auto-run gap timer.
// Optional build macro SBOX_TRACE_AMP_CHAIN_EN adds per-lane SB_LUT4 buffer
// chains that only amplify switching activity.
module sbox_trace_target
    import sbox_trace_pkg::*;
#(
    parameter int                NUM_LANES  = 4,
    parameter int                NUM_ROUNDS = 4,
    parameter int                GAP_CYCLES = 11,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEFAULT,
    parameter int                AMP_DEPTH  = 64
) (
    input  logic                        ICE_CLK,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        auto_run,
    input  logic                        dec,
    input  logic [LANE_W*NUM_LANES-1:0] key,
    output logic                        busy,
    output logic                        trigger,
    output logic                        done,
    output logic [LANE_W*NUM_LANES-1:0] text_out
);

    if (NUM_LANES < 1 || NUM_LANES > 16 || NUM_ROUNDS < 1 || NUM_ROUNDS > 15 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 255 || LFSR_SEED == '0 || AMP_DEPTH < 1) begin : g_param_bad
        $error("sbox_trace_target: parameter outside legal range");
    end

    state_t                        state;
    state_t                        state_nxt;
    logic [7:0]                    gap_cnt;
    logic [3:0]                    round_cnt;
    logic [LANE_W*NUM_LANES-1:0]   key_r;
    logic                          dec_r;
    (* keep *) logic [LANE_W*NUM_LANES-1:0] text;
    logic [LFSR_W-1:0]             lfsr_q;
    logic [LANE_W*NUM_LANES-1:0]   lane_in;
    logic [LANE_W*NUM_LANES-1:0]   lane_out;
    logic                          gap_hit;

    assign gap_hit = auto_run && (gap_cnt == 8'(GAP_CYCLES - 1));

    trace_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (ICE_CLK),
        .rst      (rst),
        .shift_en (state == ADVANCE),
        .q        (lfsr_q)
    );

    // First round takes fresh LFSR bytes (cycled every four lanes), later rounds feed back text.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_in[LANE_W*i +: LANE_W] =
            ((round_cnt == 4'd0) ? lfsr_q[LANE_W*(i%4) +: LANE_W] : text[LANE_W*i +: LANE_W])
            ^ key_r[LANE_W*i +: LANE_W];

        aes_sbox_lut u_sbox (
            .a   (lane_in[LANE_W*i +: LANE_W]),
            .inv (dec_r),
            .y   (lane_out[LANE_W*i +: LANE_W])
        );
    end

`ifdef SBOX_TRACE_AMP_CHAIN_EN
    // Identity LUT chains hanging off bit 0 of each lane; the tail is deliberately unloaded.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_amp
        (* keep *) logic [AMP_DEPTH:0] chain;
        assign chain[0] = text[LANE_W*i];
        for (genvar j = 0; j < AMP_DEPTH; j++) begin : g_cell
            (* keep *) SB_LUT4 #(.LUT_INIT(16'h0002)) u_buf (
                .O  (chain[j+1]),
                .I0 (chain[j]),
                .I1 (1'b0),
                .I2 (1'b0),
                .I3 (1'b0)
            );
        end
    end
`else
    // No amplifier chains; the keep attribute on text preserves the S-box logic.
`endif

    // State register; reset aborts any run in progress.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start and a gap expiry together launch one run.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || gap_hit) state_nxt = CLEAR;
            CLEAR:   state_nxt = ADVANCE;
            ADVANCE: state_nxt = ROUND;
            ROUND:   if (round_cnt == 4'(NUM_ROUNDS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Auto-run gap timer counts only while idling with auto_run set.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == IDLE && auto_run && state_nxt == IDLE) begin
            gap_cnt <= gap_cnt + 8'd1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Run datapath: clear text, latch key/direction, then iterate the S-box lanes.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            text      <= '0;
            key_r     <= '0;
            dec_r     <= 1'b0;
            round_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    text <= '0;
                end
                ADVANCE: begin
                    key_r     <= key;
                    dec_r     <= dec;
                    round_cnt <= '0;
                end
                ROUND: begin
                    text      <= lane_out;
                    round_cnt <= round_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign trigger  = (state == ROUND);
    assign done     = (state == DONE);
    assign text_out = text;

endmodule

// File: tb/tb_sbox_trace_target.sv
// Bench for sbox_trace_target: two instances (4 lanes x 4 rounds, 6 lanes x 1 round)
// against a behavioural run-position model and an arithmetic AES S-box.
module tb_sbox_trace_target;

    localparam int GAP  = 11;
    localparam int NL_A = 4;
    localparam int NR_A = 4;
    localparam int NL_B = 6;
    localparam int NR_B = 1;
    localparam logic [31:0] SEED = 32'hACE1ACE1;

    typedef logic [127:0] w_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = '0;
    logic [1:0]  auto_run = '0;
    logic [1:0]  dec = '0;
    logic [31:0] key_a = '0;
    logic [47:0] key_b = '0;
    logic [1:0]  busy;
    logic [1:0]  trigger;
    logic [1:0]  done;
    logic [31:0] text_a;
    logic [47:0] text_b;

    int total = 0;
    int bad   = 0;
    bit stop  = 1'b0;

    // Model: phase = position within a run (0 idle, 1 clear, 2 advance, rounds, done).
    int          phase  [2];
    int          gap_c  [2];
    logic [31:0] m_lfsr [2];
    w_t          m_text [2];
    w_t          m_pend [2];

    always #5 clk = ~clk;

    sbox_trace_target #(.NUM_LANES(NL_A), .NUM_ROUNDS(NR_A), .GAP_CYCLES(GAP),
                        .LFSR_SEED(SEED), .AMP_DEPTH(64)) dut_a (
        .ICE_CLK(clk), .rst(rst), .start(start[0]), .auto_run(auto_run[0]), .dec(dec[0]),
        .key(key_a), .busy(busy[0]), .trigger(trigger[0]), .done(done[0]), .text_out(text_a));

    sbox_trace_target #(.NUM_LANES(NL_B), .NUM_ROUNDS(NR_B), .GAP_CYCLES(GAP),
                        .LFSR_SEED(SEED), .AMP_DEPTH(64)) dut_b (
        .ICE_CLK(clk), .rst(rst), .start(start[1]), .auto_run(auto_run[1]), .dec(dec[1]),
        .key(key_b), .busy(busy[1]), .trigger(trigger[1]), .done(done[1]), .text_out(text_b));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x, input logic inv);
        logic [7:0] s;
        if (!inv) begin
            s = ginv(x);
            return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
        end
        s = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return ginv(s);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic w_t run_result(input logic [31:0] l, input w_t k, input logic dv,
                                      input int nl, input int nr);
        w_t         res;
        logic [7:0] v;
        res = '0;
        for (int i = 0; i < nl; i++) begin
            v = l[8*(i%4) +: 8];
            for (int r = 0; r < nr; r++) v = sbox_m(v ^ k[8*i +: 8], dv);
            res[8*i +: 8] = v;
        end
        return res;
    endfunction

    function automatic int nr_of(input int d);
        return (d == 0) ? NR_A : NR_B;
    endfunction

    function automatic int nl_of(input int d);
        return (d == 0) ? NL_A : NL_B;
    endfunction

    function automatic w_t key_of(input int d);
        return (d == 0) ? w_t'(key_a) : w_t'(key_b);
    endfunction

    function automatic w_t text_of(input int d);
        return (d == 0) ? w_t'(text_a) : w_t'(text_b);
    endfunction

    // Reference model, one step per clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                phase[d]  <= 0;
                gap_c[d]  <= 0;
                m_lfsr[d] <= SEED;
                m_text[d] <= '0;
                m_pend[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (phase[d] == 0) begin
                    if (start[d] || (auto_run[d] && gap_c[d] == GAP - 1)) begin
                        phase[d] <= 1;
                        gap_c[d] <= 0;
                    end else begin
                        gap_c[d] <= auto_run[d] ? gap_c[d] + 1 : 0;
                    end
                end else if (phase[d] == 2) begin
                    phase[d]  <= 3;
                    m_lfsr[d] <= lfsr_step(m_lfsr[d]);
                    m_pend[d] <= run_result(lfsr_step(m_lfsr[d]), key_of(d), dec[d],
                                            nl_of(d), nr_of(d));
                end else if (phase[d] == 2 + nr_of(d)) begin
                    phase[d]  <= phase[d] + 1;
                    m_text[d] <= m_pend[d];
                end else if (phase[d] == 3 + nr_of(d)) begin
                    phase[d] <= 0;
                end else begin
                    phase[d] <= phase[d] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input w_t act, input w_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        while (!stop) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("busy[%0d]", d), w_t'(busy[d]), w_t'(phase[d] != 0));
                check($sformatf("trigger[%0d]", d), w_t'(trigger[d]),
                      w_t'(phase[d] >= 3 && phase[d] <= 2 + nr_of(d)));
                check($sformatf("done[%0d]", d), w_t'(done[d]), w_t'(phase[d] == 3 + nr_of(d)));
                if (phase[d] == 0 || phase[d] == 3 + nr_of(d))
                    check($sformatf("text[%0d]", d), text_of(d), m_text[d]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick(1);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[d] && n < limit);
        check({tag, "_done_seen"}, w_t'(done[d]), w_t'(1));
    endtask

    task automatic wait_trigger(input int d, input int limit, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trigger[d] && n < limit);
        check({tag, "_trigger_seen"}, w_t'(trigger[d]), w_t'(1));
    endtask

    task automatic wait_idle(input int d, input int limit);
        int n;
        n = 0;
        while (busy[d] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", w_t'(busy[d]), w_t'(0));
    endtask

    task automatic stimulus();
        int n;
        int trig_cnt;
        int dn;
        int cyc;
        int nd;
        int tdone [3];

        // Model pins against known AES / LFSR values.
        check("mdl_sbox_00", w_t'(sbox_m(8'h00, 1'b0)), w_t'(8'h63));
        check("mdl_sbox_01", w_t'(sbox_m(8'h01, 1'b0)), w_t'(8'h7C));
        check("mdl_sbox_53", w_t'(sbox_m(8'h53, 1'b0)), w_t'(8'hED));
        check("mdl_isbox_63", w_t'(sbox_m(8'h63, 1'b1)), w_t'(8'h00));
        check("mdl_isbox_ED", w_t'(sbox_m(8'hED, 1'b1)), w_t'(8'h53));
        check("mdl_lfsr_1", w_t'(lfsr_step(SEED)), w_t'(32'h59C359C3));

        // Reset state.
        tick(3);
        check("rst_busy", w_t'(busy), w_t'(0));
        check("rst_trigger", w_t'(trigger), w_t'(0));
        check("rst_done", w_t'(done), w_t'(0));
        check("rst_text_a", w_t'(text_a), w_t'(0));
        rst = 1'b0;
        dec[0] = 1'b1;
        key_a  = '0;
        tick(2);

        // Single start pulse: latency, trigger width and first result.
        pulse_start(0);
        @(negedge clk);
        n = 1;
        check("busy_next_cycle", w_t'(busy[0]), w_t'(1));
        trig_cnt = int'(trigger[0]);
        while (!done[0] && n < 20) begin
            @(negedge clk);
            n++;
            trig_cnt += int'(trigger[0]);
        end
        check("done_latency", w_t'(n), w_t'(7));
        check("trigger_cycles", w_t'(trig_cnt), w_t'(4));
        check("first_text", w_t'(text_a), run_result(32'h59C359C3, '0, 1'b1, 4, 4));
        check("mdl_lfsr_after_run", w_t'(m_lfsr[0]), w_t'(32'h59C359C3));

        // Start held for 20 edges: one run per idle window.
        tick(2);
        start[0] = 1'b1;
        dn = 0;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            #2;
            if (c == 19) start[0] = 1'b0;
            @(negedge clk);
            dn += int'(done[0]);
        end
        check("held_start_runs", w_t'(dn), w_t'(3));

        // Auto-run period.
        tick(1);
        auto_run[0] = 1'b1;
        cyc = 0;
        nd  = 0;
        tdone[0] = 0; tdone[1] = 0; tdone[2] = 0;
        while (nd < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done[0]) begin
                tdone[nd] = cyc;
                nd++;
            end
        end
        check("auto_done_count", w_t'(nd), w_t'(3));
        check("auto_period_1", w_t'(tdone[1] - tdone[0]), w_t'(18));
        check("auto_period_2", w_t'(tdone[2] - tdone[1]), w_t'(18));
        tick(1);
        auto_run[0] = 1'b0;
        wait_idle(0, 20);

        // Key change during the rounds has no effect.
        tick(1);
        key_a  = 32'h01020304;
        dec[0] = 1'b0;
        pulse_start(0);
        wait_trigger(0, 10, "key");
        tick(1);
        key_a  = 32'hFFFFFFFF;
        dec[0] = 1'b1;
        wait_done(0, 20, "key");
        check("key_latched", w_t'(text_a), run_result(m_lfsr[0], w_t'(32'h01020304), 1'b0, 4, 4));

        // Reset in the second round cycle aborts the run and reseeds the LFSR.
        tick(1);
        key_a  = '0;
        dec[0] = 1'b1;
        pulse_start(0);
        wait_trigger(0, 10, "abort");
        tick(1);
        rst = 1'b1;
        #1;
        check("abort_busy", w_t'(busy[0]), w_t'(0));
        check("abort_trigger", w_t'(trigger[0]), w_t'(0));
        check("abort_text", w_t'(text_a), w_t'(0));
        tick(2);
        rst = 1'b0;
        tick(4);
        pulse_start(0);
        wait_done(0, 20, "reseed");
        check("reseed_text", w_t'(text_a), run_result(32'h59C359C3, '0, 1'b1, 4, 4));

        // Six-lane, one-round instance: lanes 4/5 reuse LFSR bytes 0/1.
        for (int r = 0; r < 3; r++) begin
            tick(1);
            key_b  = {16'($urandom), 32'($urandom)};
            dec[1] = 1'(r & 1);
            pulse_start(1);
            wait_done(1, 10, "b");
            check("b_lane4", w_t'(text_b[39:32]), w_t'(sbox_m(m_lfsr[1][7:0] ^ key_b[39:32], dec[1])));
            check("b_lane5", w_t'(text_b[47:40]), w_t'(sbox_m(m_lfsr[1][15:8] ^ key_b[47:40], dec[1])));
        end

        // Randomised traffic on both instances.
        for (int c = 0; c < 800; c++) begin
            tick(1);
            rst = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                start[d] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 39) == 0) auto_run[d] = ~auto_run[d];
                dec[d] = 1'($urandom_range(0, 1));
            end
            key_a = $urandom;
            key_b = {16'($urandom), 32'($urandom)};
        end
        tick(1);
        rst      = 1'b0;
        start    = '0;
        auto_run = '0;
        tick(30);
        stop = 1'b1;
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
